micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Next-state sequencer for the microprogrammed control unit. Each cycle it takes the next-state and condition fields of the current control word and produces the 10-bit address that indexes the microstore. It sources those addresses from the instruction-decode encoder, an incrementer, the control-word target field and a one-entry return register. It also bounds memory waits with a timeout that forces the machine back to Init.

## Interface
- `STATE_W`, 10: microstore address width.
- `INIT_STATE`, 10'd0: reset and timeout-recovery state.
- `FETCH_STATE`, 10'd1: reset value of the return register.
- `TIMEOUT`, 8'd16: maximum number of consecutive stalled wait cycles, legal range 1..255.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `n_sel`  in  3: N2..N0 field of the current control word.
- `inv`  in  1: inverts the selected condition.
- `s_sel`  in  2: S1..S0 condition select.
- `cr`  in  10: branch target field of the control word.
- `moc`  in  1: memory operation complete.
- `cond_pass`  in  1: instruction condition-code test result.
- `ir_bit`  in  1: instruction bit used for microcode branching.
- `decode_state`  in  10: entry state from the instruction encoder.
- `state`  out  10: registered current state; this is the microstore address.
- `next_state`  out  10: combinational next address.
- `ret_state`  out  10: return register, exposed for debug.
- `mem_timeout`  out  1: one-cycle pulse flagging a memory-wait timeout.

## Operation
- Condition: `c` = `sel(s_sel) ^ inv`, where `s_sel` 00 selects `moc`, 01 selects `cond_pass`, 10 selects `ir_bit`, 11 selects constant 1.
- Next-state encoding of `n_sel`:
  - 000 decode: `decode_state`.
  - 001 increment: `state+1`.
  - 010 jump: `cr`.
  - 011 conditional jump: `c` ? `cr` : `state+1`.
  - 100 conditional decode: `c` ? `decode_state` : `state+1`.
  - 101 wait: `c` ? `state+1` : `state`.
  - 110 call: `cr`; `ret_state` is loaded with `state+1`.
  - 111 return: `ret_state`.
- Incrementer width: `state+1` is computed modulo 2^10, so 1023 wraps to 0.
- Return register: only one level deep. A nested call overwrites it. A return with no prior call goes to `FETCH_STATE`.
- Wait counter (8 bits):
  - Increments on each cycle with `n_sel`=101 and `c`=0.
  - Clears on any other cycle.
  - If the counter equals `TIMEOUT-1` while still stalled, `next_state` is forced to `INIT_STATE`, the counter clears and `mem_timeout` is set at that edge.
- Simultaneous events: a timeout forcing takes priority over every `n_sel` mode. A wait that completes on the same cycle the counter reaches `TIMEOUT-1` is not a timeout; `c`=1 wins.

## Timing
- Reset values: `state`=`INIT_STATE`, `ret_state`=`FETCH_STATE`, counter=0, `mem_timeout`=0. `next_state` is combinational and reflects the reset `state`.
- The microstore is combinational, so the control word for `state` is valid in the same cycle. `state` <= `next_state` on every rising edge, giving one microinstruction per cycle.
- `mem_timeout` is registered: it is high for exactly one cycle, the cycle in which `state`=`INIT_STATE` after the forcing edge.
- `ret_state` updates on the same edge that `state` takes the call target.
- Reset asserted mid-wait or mid-call: all registers return to their reset values immediately; no pending return or timeout survives.
- Inputs only need to be stable before the rising edge. There is no handshake other than `moc`.

## Structure
- Shared control-unit package holds:
  - `n_sel` encodings (`N_DECODE`, `N_INC`, `N_JUMP`, `N_CJUMP`, `N_CDECODE`, `N_WAIT`, `N_CALL`, `N_RET`).
  - `s_sel` encodings (`S_MOC`, `S_COND`, `S_IRBIT`, `S_ONE`).
  - `INIT_STATE`, `FETCH_STATE`.
- One sub-module, `cond_select`: the 4:1 condition mux plus `inv`, purely combinational.
- The sequencer top holds the `state` register, incrementer, return register, wait counter and next-state mux.

## Test plan
- Reset release with `n_sel`=001: `state` reads 0, then 1, 2, 3 on successive edges; `ret_state`=1.
- Fetch wait, `n_sel`=101, `s_sel`=00, `inv`=0, with `moc` low for 3 cycles then high: `state` holds at 3 for 3 cycles, advances to 4 on the 4th edge, `mem_timeout` stays 0.
- With `moc` held low and `TIMEOUT`=16: after 16 stalled cycles `state`=0 and `mem_timeout` is high for exactly 1 cycle. With `moc` rising on stall cycle 16, `state` goes to `state+1` and `mem_timeout` stays 0.
- Conditional jump, `n_sel`=011, `cr`=40, in state 36: `cond_pass`=1 with `inv`=0 gives 40; `cond_pass`=1 with `inv`=1 gives 37.
- Call and return: `n_sel`=110, `cr`=20 in state 4 gives `state`=20 and `ret_state`=5. A later `n_sel`=111 gives `state`=5. A return after reset with no call gives `state`=1.
- Wrap-around and reset: in state 1023 with `n_sel`=001 the next state is 0. Asserting `reset_n`=0 while in state 22 immediately gives `state`=0 and `ret_state`=1.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// micro_sequencer_pkg
// Shared control-unit definitions for the microprogrammed sequencer:
//   - n_sel next-state mode encodings (N2..N0 field of the control word)
//   - s_sel condition select encodings (S1..S0 field of the control word)
//   - default Init / Fetch microstore addresses
// ----------------------------------------------------------------------------
package micro_sequencer_pkg;

   localparam int unsigned SEQ_STATE_W = 10;

   // Init is both the reset target and the memory-timeout recovery target.
   // Fetch is where an unmatched return lands.
   localparam logic [SEQ_STATE_W-1:0] INIT_STATE  = 10'd0;
   localparam logic [SEQ_STATE_W-1:0] FETCH_STATE = 10'd1;

   typedef enum logic [2:0] {
      N_DECODE  = 3'b000,
      N_INC     = 3'b001,
      N_JUMP    = 3'b010,
      N_CJUMP   = 3'b011,
      N_CDECODE = 3'b100,
      N_WAIT    = 3'b101,
      N_CALL    = 3'b110,
      N_RET     = 3'b111
   } n_sel_e;

   typedef enum logic [1:0] {
      S_MOC   = 2'b00,
      S_COND  = 2'b01,
      S_IRBIT = 2'b10,
      S_ONE   = 2'b11
   } s_sel_e;

endpackage

// File: rtl/micro_sequencer_cond_select.sv
// ----------------------------------------------------------------------------
// micro_sequencer_cond_select (cond_select)
// Purely combinational branch-condition generator: 4:1 mux over the
// condition sources followed by an optional inversion.
// Ports:
//   i_s_sel     in  2  condition select (moc / cond_pass / ir_bit / 1)
//   i_inv       in  1  inverts the selected condition
//   i_moc       in  1  memory operation complete
//   i_cond_pass in  1  instruction condition-code test result
//   i_ir_bit    in  1  instruction bit for microcode branching
//   o_c         out 1  final condition c = sel(s_sel) ^ inv
// ----------------------------------------------------------------------------
module cond_select (
   input  logic [1:0] i_s_sel,
   input  logic       i_inv,
   input  logic       i_moc,
   input  logic       i_cond_pass,
   input  logic       i_ir_bit,
   output logic       o_c
);
   import micro_sequencer_pkg::*;

   s_sel_e w_sel_mode;
   logic   w_sel;

   assign w_sel_mode = s_sel_e'(i_s_sel);

   always_comb begin
      w_sel = 1'b1;
      case (w_sel_mode)
         S_MOC:   w_sel = i_moc;
         S_COND:  w_sel = i_cond_pass;
         S_IRBIT: w_sel = i_ir_bit;
         S_ONE:   w_sel = 1'b1;
         default: w_sel = 1'b1;
      endcase
   end

   assign o_c = w_sel ^ i_inv;

endmodule

// File: rtl/micro_sequencer.sv
// ----------------------------------------------------------------------------
// micro_sequencer
// Next-state sequencer for the microprogrammed control unit. Each cycle it
// picks the next microstore address from the decode entry, the incrementer,
// the control-word target or the one-deep return register, and bounds
// memory waits with a timeout that forces the machine back to Init.
// Ports:
//   clk          in  1   rising-edge clock
//   reset_n      in  1   asynchronous active-low reset
//   n_sel        in  3   next-state mode (N2..N0)
//   inv          in  1   inverts the selected condition
//   s_sel        in  2   condition select (S1..S0)
//   cr           in  10  branch/call target field
//   moc          in  1   memory operation complete
//   cond_pass    in  1   instruction condition-code test result
//   ir_bit       in  1   instruction bit for microcode branching
//   decode_state in  10  entry state from the instruction encoder
//   state        out 10  registered current state (microstore address)
//   next_state   out 10  combinational next address
//   ret_state    out 10  return register (debug view)
//   mem_timeout  out 1   one-cycle pulse after a memory-wait timeout
// ----------------------------------------------------------------------------
module micro_sequencer #(
   parameter int unsigned        STATE_W     = 10,
   parameter logic [STATE_W-1:0] INIT_STATE  = micro_sequencer_pkg::INIT_STATE,
   parameter logic [STATE_W-1:0] FETCH_STATE = micro_sequencer_pkg::FETCH_STATE,
   parameter logic [7:0]         TIMEOUT     = 8'd16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         n_sel,
   input  logic               inv,
   input  logic [1:0]         s_sel,
   input  logic [STATE_W-1:0] cr,
   input  logic               moc,
   input  logic               cond_pass,
   input  logic               ir_bit,
   input  logic [STATE_W-1:0] decode_state,
   output logic [STATE_W-1:0] state,
   output logic [STATE_W-1:0] next_state,
   output logic [STATE_W-1:0] ret_state,
   output logic               mem_timeout
);
   import micro_sequencer_pkg::*;

   // Counter value on the last tolerated stall cycle.
   localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] r_ret_state;
   logic [7:0]         r_wait_cnt;
   logic               r_mem_timeout;

   n_sel_e             w_mode;
   logic               w_c;
   logic [STATE_W-1:0] w_inc;
   logic [STATE_W-1:0] w_mode_next;
   logic               w_stall;
   logic               w_timeout;

   cond_select u_cond_select (
      .i_s_sel     (s_sel),
      .i_inv       (inv),
      .i_moc       (moc),
      .i_cond_pass (cond_pass),
      .i_ir_bit    (ir_bit),
      .o_c         (w_c)
   );

   assign w_mode = n_sel_e'(n_sel);

   // Incrementer wraps naturally at the top of the microstore.
   assign w_inc = r_state + {{(STATE_W-1){1'b0}}, 1'b1};

   // A stall is a wait whose condition is false; a completing wait (c=1)
   // on the last tolerated cycle is therefore never a timeout.
   assign w_stall   = (w_mode == N_WAIT) && !w_c;
   assign w_timeout = w_stall && (r_wait_cnt == TIMEOUT_LAST);

   always_comb begin
      w_mode_next = w_inc;
      case (w_mode)
         N_DECODE:  w_mode_next = decode_state;
         N_INC:     w_mode_next = w_inc;
         N_JUMP:    w_mode_next = cr;
         N_CJUMP:   w_mode_next = w_c ? cr : w_inc;
         N_CDECODE: w_mode_next = w_c ? decode_state : w_inc;
         N_WAIT:    w_mode_next = w_c ? w_inc : r_state;
         N_CALL:    w_mode_next = cr;
         N_RET:     w_mode_next = r_ret_state;
         default:   w_mode_next = w_inc;
      endcase
   end

   // Timeout recovery overrides every n_sel mode.
   assign next_state = w_timeout ? INIT_STATE : w_mode_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= INIT_STATE;
         r_ret_state   <= FETCH_STATE;
         r_wait_cnt    <= 8'd0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state       <= next_state;
         r_mem_timeout <= w_timeout;
         if (w_mode == N_CALL) begin
            r_ret_state <= w_inc;
         end
         if (w_stall && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end else begin
            r_wait_cnt <= 8'd0;
         end
      end
   end

   assign state       = r_state;
   assign ret_state   = r_ret_state;
   assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_micro_sequencer.sv
// ----------------------------------------------------------------------------
// tb_micro_sequencer
// Directed self-checking bench for micro_sequencer. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_micro_sequencer;

   logic       clk;
   logic       reset_n;
   logic [2:0] n_sel;
   logic       inv;
   logic [1:0] s_sel;
   logic [9:0] cr;
   logic       moc;
   logic       cond_pass;
   logic       ir_bit;
   logic [9:0] decode_state;
   logic [9:0] state;
   logic [9:0] next_state;
   logic [9:0] ret_state;
   logic       mem_timeout;

   int checks = 0;
   int errors = 0;

   micro_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .n_sel        (n_sel),
      .inv          (inv),
      .s_sel        (s_sel),
      .cr           (cr),
      .moc          (moc),
      .cond_pass    (cond_pass),
      .ir_bit       (ir_bit),
      .decode_state (decode_state),
      .state        (state),
      .next_state   (next_state),
      .ret_state    (ret_state),
      .mem_timeout  (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
      $display("check %-14s observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; n_sel = 3'b001; inv = 1'b0; s_sel = 2'b00; cr = 10'd0;
      moc = 1'b0; cond_pass = 1'b0; ir_bit = 1'b0; decode_state = 10'd0;
      step(); step();
      chk("rst_state", state, 0);
      chk("rst_ret", ret_state, 1);
      chk("rst_tmo", mem_timeout, 0);
      chk("rst_next", next_state, 1);

      // Reset release, increment 0 -> 1 -> 2 -> 3
      reset_n = 1'b1;
      chk("rel_state0", state, 0);
      step(); chk("inc_1", state, 1);
      step(); chk("inc_2", state, 2);
      step(); chk("inc_3", state, 3);
      chk("inc_ret", ret_state, 1);

      // Fetch wait: moc low for 3 edges, then high
      n_sel = 3'b101; s_sel = 2'b00; inv = 1'b0; moc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk("wait_hold", state, 3); chk("wait_tmo", mem_timeout, 0);
      end
      moc = 1'b1;
      step(); chk("wait_done", state, 4); chk("wait_done_tmo", mem_timeout, 0);

      // Full timeout: 15 stalls hold, 16th forces Init
      moc = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(); chk("tmo_hold", state, 4); chk("tmo_hold_p", mem_timeout, 0);
      end
      step(); chk("tmo_state", state, 0); chk("tmo_pulse", mem_timeout, 1);
      n_sel = 3'b001;
      #1 chk("tmo_next", next_state, 1);
      step(); chk("tmo_after", state, 1); chk("tmo_pulse_end", mem_timeout, 0);

      // moc rising on stall cycle 16: completes, no timeout
      n_sel = 3'b101; moc = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("late_hold", state, 1);
      moc = 1'b1;
      step(); chk("late_done", state, 2); chk("late_tmo", mem_timeout, 0);
      n_sel = 3'b001;
      step(); chk("late_tmo2", mem_timeout, 0); chk("late_inc", state, 3);

      // Conditional jump from 36
      n_sel = 3'b010; cr = 10'd36;
      step(); chk("jmp_36", state, 36);
      n_sel = 3'b011; cr = 10'd40; s_sel = 2'b01; cond_pass = 1'b1; inv = 1'b0;
      #1 chk("cj_next", next_state, 40);
      step(); chk("cj_taken", state, 40);
      n_sel = 3'b010; cr = 10'd36;
      step();
      n_sel = 3'b011; cr = 10'd40; inv = 1'b1;
      step(); chk("cj_inv", state, 37);

      // ir_bit and constant-one selects
      n_sel = 3'b011; cr = 10'd100; s_sel = 2'b10; ir_bit = 1'b1; inv = 1'b0;
      step(); chk("cj_irbit", state, 100);
      s_sel = 2'b11; inv = 1'b1;
      step(); chk("cj_one_inv", state, 101);

      // Decode and conditional decode
      n_sel = 3'b100; s_sel = 2'b11; inv = 1'b0; decode_state = 10'd300;
      step(); chk("cdec_taken", state, 300);
      n_sel = 3'b000; decode_state = 10'd512;
      step(); chk("decode", state, 512);
      n_sel = 3'b100; inv = 1'b1;
      step(); chk("cdec_not", state, 513);

      // Call and return
      n_sel = 3'b010; cr = 10'd4; inv = 1'b0;
      step();
      n_sel = 3'b110; cr = 10'd20;
      step(); chk("call_state", state, 20); chk("call_ret", ret_state, 5);
      n_sel = 3'b001;
      step(); chk("call_inc", state, 21);
      n_sel = 3'b111;
      step(); chk("ret_state", state, 5);
      n_sel = 3'b110; cr = 10'd50;
      step(); chk("call2_ret", ret_state, 6);
      cr = 10'd70;
      step(); chk("nest_state", state, 70); chk("nest_ret", ret_state, 51);
      n_sel = 3'b111;
      step(); chk("nest_return", state, 51);

      // Wrap-around
      n_sel = 3'b010; cr = 10'd1023;
      step(); chk("at_1023", state, 1023);
      n_sel = 3'b001;
      #1 chk("wrap_next", next_state, 0);
      step(); chk("wrap", state, 0);

      // Asynchronous reset in state 22 with a pending return address
      n_sel = 3'b010; cr = 10'd22;
      step(); chk("at_22", state, 22);
      reset_n = 1'b0;
      #1 chk("arst_state", state, 0); chk("arst_ret", ret_state, 1);
      step();
      reset_n = 1'b1; n_sel = 3'b111;
      step(); chk("ret_nocall", state, 1);

      // Reset mid-wait clears the stall count
      n_sel = 3'b101; s_sel = 2'b00; moc = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(); chk("rw_hold_p", mem_timeout, 0);
      end
      chk("rw_hold", state, 0);
      step(); chk("rw_tmo", mem_timeout, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
